video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 104 ++++++++++
 tb/tb_video_timing_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: PLL-lock-qualified raster timing (hs/vs/de, x/y, sof/sol) with registered outputs.
// Define VTG_COLOR_BAR_EN to drive an 8-bar test pattern on rgb_o; otherwise rgb_o is constant 0.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE    = 1920,
  parameter int unsigned H_FP        = 88,
  parameter int unsigned H_SYNC      = 44,
  parameter int unsigned H_BP        = 148,
  parameter int unsigned V_ACTIVE    = 1080,
  parameter int unsigned V_FP        = 4,
  parameter int unsigned V_SYNC      = 5,
  parameter int unsigned V_BP        = 36,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned LOCK_STABLE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_lock_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [11:0] x_o,
  output logic [10:0] y_o,
  output logic        sof_o,
  output logic        sol_o,
  output logic [23:0] rgb_o
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t        state_q, state_d;
  logic          lock_meta_q, lock_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [11:0]   hcnt_q, hcnt_d;
  logic [10:0]   vcnt_q, vcnt_d;
  logic          run, h_act, v_act, de_d;
  logic [23:0]   rgb_d;

  // a lock drop is acted on in the same cycle it is seen, so outputs never show a stale RUN cycle
  always_comb begin
    run     = state_q == RUN && lock_q;
    h_act   = hcnt_q < H_ACT;
    v_act   = vcnt_q < V_ACT;
    de_d    = run && h_act && v_act;
    state_d = lock_q && (state_q == RUN || stab_q == STAB_LAST) ? RUN : WAIT_LOCK;
    stab_d  = lock_q && state_q == WAIT_LOCK && stab_q != STAB_LAST ? stab_q + 1'b1 : '0;
    hcnt_d  = !run || hcnt_q == H_LAST ? '0 : hcnt_q + 1'b1;
    vcnt_d  = !run ? '0 : hcnt_q != H_LAST ? vcnt_q : vcnt_q == V_LAST ? '0 : vcnt_q + 1'b1;
  end

`ifdef VTG_COLOR_BAR_EN
  logic [2:0] bar;
  assign bar   = 3'({hcnt_q, 3'b000} / 15'(H_ACTIVE));
  assign rgb_d = de_d ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : '0;
`else
  assign rgb_d = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      lock_meta_q <= 1'b0;
      lock_q      <= 1'b0;
      stab_q      <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      hs_o        <= ~HS_POL;
      vs_o        <= ~VS_POL;
      de_o        <= 1'b0;
      x_o         <= '0;
      y_o         <= '0;
      sof_o       <= 1'b0;
      sol_o       <= 1'b0;
      rgb_o       <= '0;
    end else begin
      lock_meta_q <= pll_lock_i;
      lock_q      <= lock_meta_q;
      state_q     <= state_d;
      stab_q      <= stab_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      hs_o        <= run && hcnt_q >= H_SS && hcnt_q < H_SE ? HS_POL : ~HS_POL;
      vs_o        <= run && vcnt_q >= V_SS && vcnt_q < V_SE ? VS_POL : ~VS_POL;
      de_o        <= de_d;
      x_o         <= de_d ? hcnt_q : '0;
      y_o         <= de_d ? vcnt_q : '0;
      sof_o       <= run && hcnt_q == '0 && vcnt_q == '0;
      sol_o       <= run && hcnt_q == '0 && v_act;
      rgb_o       <= rgb_d;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of video_timing_gen with small timing (H 16/2/3/4, V 8/1/2/3, lock 4).
module tb_video_timing_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_lock_i = 1'b1;
  logic        hs_o, vs_o, de_o, sof_o, sol_o;
  logic [11:0] x_o;
  logic [10:0] y_o;
  logic [23:0] rgb_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] bars [8];

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_STABLE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .x_o(x_o), .y_o(y_o),
    .sof_o(sof_o), .sol_o(sol_o), .rgb_o(rgb_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_sof(output int n, output bit de_seen);
    n = 0;
    de_seen = 1'b0;
    while (n < 40) begin
      step();
      n++;
      if (sof_o) break;
      if (de_o) de_seen = 1'b1;
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int r);
    int h = r % 25;
    int v = r / 25;
`ifdef VTG_COLOR_BAR_EN
    return (h < 16 && v < 8) ? bars[h / 2] : 24'h0;
`else
    return (h < 16 && v < 8) ? 24'h0 : 24'h0;
`endif
  endfunction

  // samples one frame starting at the sof cycle (r=0), then expects the next sof 350 cycles later
  task automatic frame_check(input string tag);
    int de_n = 0, hs_n = 0, vs_n = 0, sol_n = 0, sof_n = 0, rgb_err = 0;
    for (int r = 0; r < 350; r++) begin
      if (r > 0) step();
      de_n += int'(de_o);
      hs_n += int'(hs_o);
      vs_n += int'(vs_o);
      sol_n += int'(sol_o);
      sof_n += int'(sof_o);
      if (rgb_o !== exp_rgb(r)) rgb_err++;
      if (r == 0)   chk({tag, "_rgb_x0"}, rgb_o, exp_rgb(0));
      if (r == 3)   chk({tag, "_rgb_x3"}, rgb_o, exp_rgb(3));
      if (r == 9)   chk({tag, "_rgb_x9"}, rgb_o, exp_rgb(9));
      if (r == 15)  chk({tag, "_rgb_x15"}, rgb_o, exp_rgb(15));
      if (r == 5)   chk({tag, "_xy_5_0"}, {de_o, 4'h0, x_o, 5'h0, y_o}, {1'b1, 4'h0, 12'd5, 5'h0, 11'd0});
      if (r == 82)  chk({tag, "_xy_7_3"}, {de_o, 4'h0, x_o, 5'h0, y_o}, {1'b1, 4'h0, 12'd7, 5'h0, 11'd3});
      if (r == 16)  chk({tag, "_blank_x16"}, {de_o, x_o}, 13'd0);
      if (r == 200) chk({tag, "_blank_y8"}, {de_o, 1'b0, y_o}, 13'd0);
      if (r == 17)  chk({tag, "_hs_17"}, hs_o, 1'b0);
      if (r == 18)  chk({tag, "_hs_18"}, hs_o, 1'b1);
      if (r == 20)  chk({tag, "_hs_20"}, hs_o, 1'b1);
      if (r == 21)  chk({tag, "_hs_21"}, hs_o, 1'b0);
      if (r == 224) chk({tag, "_vs_224"}, vs_o, 1'b0);
      if (r == 225) chk({tag, "_vs_225"}, vs_o, 1'b1);
      if (r == 274) chk({tag, "_vs_274"}, vs_o, 1'b1);
      if (r == 275) chk({tag, "_vs_275"}, vs_o, 1'b0);
      if (r == 25)  chk({tag, "_sol_line1"}, sol_o, 1'b1);
      if (r == 225) chk({tag, "_sol_line9"}, sol_o, 1'b0);
    end
    chk({tag, "_de_count"}, de_n, 128);
    chk({tag, "_hs_count"}, hs_n, 42);
    chk({tag, "_vs_count"}, vs_n, 50);
    chk({tag, "_sol_count"}, sol_n, 8);
    chk({tag, "_sof_count"}, sof_n, 1);
    chk({tag, "_rgb_errs"}, rgb_err, 0);
    step();
    chk({tag, "_sof_period"}, sof_o, 1'b1);
  endtask

  initial begin
    int  n;
    bit  de_seen, found;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    repeat (3) @(negedge clk);
    chk("rst_de", de_o, 1'b0);
    chk("rst_hs", hs_o, 1'b0);
    chk("rst_vs", vs_o, 1'b0);
    chk("rst_sof_sol", {sof_o, sol_o}, 2'b00);
    chk("rst_xy", {x_o, y_o}, 23'd0);
    chk("rst_rgb", rgb_o, 24'h0);
    rst_n = 1'b1;
    wait_sof(n, de_seen);
    chk("first_sof_edges", n, 7);
    chk("first_no_de_before_sof", de_seen, 1'b0);
    frame_check("f1");

    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      found = de_o && x_o == 12'd10 && y_o == 11'd5;
    end
    chk("drop_found_10_5", found, 1'b1);
    pll_lock_i = 1'b0;
    step();
    chk("drop_e1", {de_o, x_o}, {1'b1, 12'd11});
    step();
    chk("drop_e2", {de_o, x_o}, {1'b1, 12'd12});
    step();
    chk("drop_inactive", {de_o, hs_o, vs_o, sof_o, sol_o, x_o, y_o}, 28'd0);
    pll_lock_i = 1'b1;
    wait_sof(n, de_seen);
    chk("drop_restart_edges", n, 7);
    chk("drop_no_de_before_sof", de_seen, 1'b0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    pll_lock_i = 1'b0;
    step();
    pll_lock_i = 1'b1;
    wait_sof(n, de_seen);
    chk("glitch_restart_edges", n, 7);
    chk("glitch_no_de_before_sof", de_seen, 1'b0);

    repeat (4) step();
    chk("midline_active", {de_o, x_o}, {1'b1, 12'd4});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_de_x", {de_o, x_o}, 13'd0);
    chk("async_rst_rgb", rgb_o, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sof(n, de_seen);
    chk("rerun_sof_edges", n, 7);
    chk("rerun_no_de_before_sof", de_seen, 1'b0);
    frame_check("f2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
